// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-box VGA renderer.
//   H_ACTIVE / V_ACTIVE : visible area of the 640x480 timing this block feeds
//   rgb12_t             : 12-bit colour {r,g,b}, 4 bits each
//   dir_t               : per-axis motion direction (increasing / decreasing)
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_t;

endpackage

// File: rtl/box_axis_motion.sv
// One axis of box motion: position register plus direction FSM.
//   clk, rst : pixel clock, asynchronous active-high reset
//   update   : advance the position by one step this cycle
//   pos      : current box edge (left or top), registered
//   bounce   : combinational, high when this update hits a limit and reverses
module box_axis_motion #(
  parameter int unsigned LIMIT = 640,
  parameter int unsigned SIZE  = 100,
  parameter int unsigned STEP  = 2,
  parameter int unsigned INIT  = 270
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  output logic [9:0] pos,
  output logic       bounce
);
  import vga_pkg::*;

  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] SIZE_W  = 11'(SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [9:0]  MAX_POS = 10'(LIMIT - SIZE);
  localparam logic [9:0]  INIT_W  = 10'(INIT);

  dir_t       dir;
  logic       hit_inc;
  logic       hit_dec;
  logic [10:0] pos_w;

  // 11-bit arithmetic keeps pos+STEP+SIZE from wrapping near the far edge.
  always_comb begin
    pos_w   = {1'b0, pos};
    hit_inc = (pos_w + STEP_W + SIZE_W) > LIMIT_W;
    hit_dec = pos_w < STEP_W;
    bounce  = update && ((dir == DIR_INC) ? hit_inc : hit_dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= INIT_W;
      dir <= DIR_INC;
    end else if (update) begin
      case (dir)
        DIR_INC: begin
          if (hit_inc) begin
            pos <= MAX_POS;
            dir <= DIR_DEC;
          end else begin
            pos <= pos + STEP_W[9:0];
          end
        end
        DIR_DEC: begin
          if (hit_dec) begin
            pos <= '0;
            dir <= DIR_INC;
          end else begin
            pos <= pos - STEP_W[9:0];
          end
        end
        default: begin
          pos <= INIT_W;
          dir <= DIR_INC;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel-colour source for a solid box bouncing around the visible area.
//   CLK_25, RESET        : pixel clock, asynchronous active-high reset
//   run                  : 1 enables motion, 0 freezes position and divider
//   pix_en, pix_x, pix_y : active-video flag and coordinates from timing stage
//   frame_start          : once-per-frame pulse in vertical blanking
//   VGA_R/G/B            : registered colour, 1-cycle latency
//   pix_valid            : pix_en delayed by one cycle
//   box_x, box_y         : current box top-left corner
//   hit_edge             : 1-cycle pulse when any axis bounced on an update
module vga_box_renderer #(
  parameter int unsigned H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int unsigned BOX_SIZE  = 100,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [11:0] BOX_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic       CLK_25,
  input  logic       RESET,
  input  logic       run,
  input  logic       pix_en,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       frame_start,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       pix_valid,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       hit_edge
);
  import vga_pkg::*;

  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [10:0] SIZE_M1  = 11'(BOX_SIZE - 1);

  logic [7:0] divider;
  logic       fire;
  logic       bounce_x;
  logic       bounce_y;
  logic       in_box;
  rgb12_t     rgb;

  assign fire = frame_start && run && (divider == DIV_LAST);

  box_axis_motion #(
    .LIMIT(H_ACTIVE),
    .SIZE (BOX_SIZE),
    .STEP (STEP),
    .INIT ((H_ACTIVE - BOX_SIZE) / 2)
  ) u_axis_x (
    .clk   (CLK_25),
    .rst   (RESET),
    .update(fire),
    .pos   (box_x),
    .bounce(bounce_x)
  );

  box_axis_motion #(
    .LIMIT(V_ACTIVE),
    .SIZE (BOX_SIZE),
    .STEP (STEP),
    .INIT ((V_ACTIVE - BOX_SIZE) / 2)
  ) u_axis_y (
    .clk   (CLK_25),
    .rst   (RESET),
    .update(fire),
    .pos   (box_y),
    .bounce(bounce_y)
  );

  // Compare against the position currently registered, so a frame_start
  // landing on an active pixel still renders that pixel at the old position.
  always_comb begin
    in_box = ({1'b0, pix_x} >= {1'b0, box_x}) &&
             ({1'b0, pix_x} <= ({1'b0, box_x} + SIZE_M1)) &&
             ({1'b0, pix_y} >= {1'b0, box_y}) &&
             ({1'b0, pix_y} <= ({1'b0, box_y} + SIZE_M1));
  end

  always_ff @(posedge CLK_25 or posedge RESET) begin
    if (RESET) begin
      divider   <= '0;
      hit_edge  <= 1'b0;
      pix_valid <= 1'b0;
      rgb       <= '0;
    end else begin
      if (frame_start && run) begin
        divider <= fire ? '0 : divider + 8'd1;
      end
      hit_edge  <= bounce_x || bounce_y;
      pix_valid <= pix_en;
      if (!pix_en) begin
        rgb <= '0;
      end else if (in_box) begin
        rgb <= BOX_COLOR;
      end else begin
        rgb <= BG_COLOR;
      end
    end
  end

  assign VGA_R = rgb.r;
  assign VGA_G = rgb.g;
  assign VGA_B = rgb.b;

endmodule

// File: tb/tb_vga_box_renderer.sv
module tb_vga_box_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       pix_en;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_start;

  logic [3:0] r0, g0, b0;
  logic       pv0, hit0;
  logic [9:0] bx0, by0;
  logic [3:0] r1, g1, b1;
  logic       pv1, hit1;
  logic [9:0] bx1, by1;

  always #20 clk = ~clk;

  // Default parameters: box 100, step 2, update every frame.
  vga_box_renderer dut (
    .CLK_25(clk), .RESET(rst), .run(run), .pix_en(pix_en), .pix_x(pix_x),
    .pix_y(pix_y), .frame_start(frame_start), .VGA_R(r0), .VGA_G(g0),
    .VGA_B(b0), .pix_valid(pv0), .box_x(bx0), .box_y(by0), .hit_edge(hit0)
  );

  // Big box, big step, divide by 3: the first update hits a corner.
  vga_box_renderer #(
    .BOX_SIZE(300), .STEP(200), .FRAME_DIV(3)
  ) dut_c (
    .CLK_25(clk), .RESET(rst), .run(run), .pix_en(pix_en), .pix_x(pix_x),
    .pix_y(pix_y), .frame_start(frame_start), .VGA_R(r1), .VGA_G(g1),
    .VGA_B(b1), .pix_valid(pv1), .box_x(bx1), .box_y(by1), .hit_edge(hit1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int p;
    bit dec;
    bit b;
  } ax_t;

  int  SZ [2] = '{100, 300};
  int  ST [2] = '{2, 200};
  int  DV [2] = '{1, 3};
  ax_t mx [2];
  ax_t my [2];
  int  mdiv [2];
  bit  mhit [2];
  logic [11:0] sb_rgb[$];

  function automatic ax_t ax_next(ax_t a, int lim, int size, int step);
    ax_t n;
    n = a;
    n.b = 1'b0;
    if (!a.dec) begin
      if (a.p + step + size > lim) begin
        n.p = lim - size; n.dec = 1'b1; n.b = 1'b1;
      end else n.p = a.p + step;
    end else begin
      if (a.p < step) begin
        n.p = 0; n.dec = 1'b0; n.b = 1'b1;
      end else n.p = a.p - step;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = '{(640 - SZ[i]) / 2, 1'b0, 1'b0};
      my[i] = '{(480 - SZ[i]) / 2, 1'b0, 1'b0};
      mdiv[i] = 0;
      mhit[i] = 1'b0;
    end
    sb_rgb.delete();
  endtask

  function automatic logic [11:0] model_rgb(bit en, int x, int y);
    if (!en) return 12'h000;
    if (x >= mx[0].p && x <= mx[0].p + 99 && y >= my[0].p && y <= my[0].p + 99)
      return 12'hFFF;
    return 12'h00F;
  endfunction

  // One clock: drive, push expected colour, advance model, check after edge.
  task automatic cycle(input bit en, input int x, input int y, input bit fs,
                       input logic [11:0] exp_rgb);
    logic [11:0] e;
    pix_en = en;
    pix_x = 10'(x);
    pix_y = 10'(y);
    frame_start = fs;
    sb_rgb.push_back(exp_rgb);
    for (int i = 0; i < 2; i++) begin
      mhit[i] = 1'b0;
      if (fs && run) begin
        if (mdiv[i] == DV[i] - 1) begin
          mdiv[i] = 0;
          mx[i] = ax_next(mx[i], 640, SZ[i], ST[i]);
          my[i] = ax_next(my[i], 480, SZ[i], ST[i]);
          mhit[i] = mx[i].b | my[i].b;
        end else mdiv[i]++;
      end
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    e = sb_rgb.pop_front();
    chk("rgb", int'({r0, g0, b0}), int'(e));
    chk("pix_valid", int'(pv0), int'(en));
    chk("box_x", int'(bx0), mx[0].p);
    chk("box_y", int'(by0), my[0].p);
    chk("hit_edge", int'(hit0), int'(mhit[0]));
    chk("c_box_x", int'(bx1), mx[1].p);
    chk("c_box_y", int'(by1), my[1].p);
    chk("c_hit_edge", int'(hit1), int'(mhit[1]));
  endtask

  typedef struct {
    bit          en;
    int          x;
    int          y;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[$];
  int   hold_x;
  int   hold_y;

  initial begin
    vecs = '{
      '{1'b1, 270, 190, 12'hFFF},
      '{1'b1, 369, 190, 12'hFFF},
      '{1'b1, 370, 190, 12'h00F},
      '{1'b0, 300, 200, 12'h000},
      '{1'b1, 269, 200, 12'h00F},
      '{1'b1, 300, 189, 12'h00F},
      '{1'b1, 300, 289, 12'hFFF},
      '{1'b1, 300, 290, 12'h00F},
      '{1'b1, 0,   0,   12'h00F},
      '{1'b1, 639, 479, 12'h00F}
    };

    rst = 1'b1; run = 1'b1; pix_en = 1'b0; pix_x = '0; pix_y = '0;
    frame_start = 1'b0;
    model_reset();
    #50;
    chk("rst_box_x", int'(bx0), 270);
    chk("rst_box_y", int'(by0), 190);
    chk("rst_rgb", int'({r0, g0, b0}), 0);
    chk("rst_pix_valid", int'(pv0), 0);
    chk("rst_hit_edge", int'(hit0), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) cycle(vecs[i].en, vecs[i].x, vecs[i].y, 1'b0, vecs[i].rgb);

    // frame_start during active video: pixel still uses pre-update x=270.
    cycle(1'b1, 270, 200, 1'b1, 12'hFFF);
    chk("first_move_x", int'(bx0), 272);
    chk("first_move_y", int'(by0), 192);
    cycle(1'b1, 270, 200, 1'b0, 12'h00F);

    // Divide-by-3 instance: two more pulses, only the third moves it (corner).
    cycle(1'b0, 0, 0, 1'b1, 12'h000);
    chk("div3_hold_x", int'(bx1), 170);
    cycle(1'b0, 0, 0, 1'b1, 12'h000);
    chk("corner_x", int'(bx1), 340);
    chk("corner_y", int'(by1), 180);
    chk("corner_hit", int'(hit1), 1);
    cycle(1'b0, 0, 0, 1'b0, 12'h000);
    chk("corner_hit_end", int'(hit1), 0);

    // Long run through several bounces on both axes of the main instance.
    for (int n = 0; n < 320; n++) begin
      int x, y;
      bit en;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) begin
        x = mx[0].p + $urandom_range(0, 101) - 1;
        y = my[0].p + $urandom_range(0, 101) - 1;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      cycle(en, x, y, 1'b1, model_rgb(en, x, y));
      cycle(en, x, y, 1'b0, model_rgb(en, x, y));
    end

    // Frozen motion.
    run = 1'b0;
    hold_x = int'(bx0);
    hold_y = int'(by0);
    for (int n = 0; n < 10; n++) begin
      cycle(1'b0, 0, 0, 1'b1, 12'h000);
      cycle(1'b0, 0, 0, 1'b0, 12'h000);
    end
    chk("frozen_x", int'(bx0), hold_x);
    chk("frozen_y", int'(by0), hold_y);
    run = 1'b1;

    // Asynchronous reset mid-line while the box is being drawn.
    cycle(1'b1, mx[0].p, my[0].p, 1'b0, 12'hFFF);
    pix_en = 1'b1;
    #5 rst = 1'b1;
    #1;
    chk("async_rgb", int'({r0, g0, b0}), 0);
    chk("async_pix_valid", int'(pv0), 0);
    chk("async_box_x", int'(bx0), 270);
    chk("async_box_y", int'(by0), 190);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 270, 190, 1'b0, 12'hFFF);
    cycle(1'b1, 370, 290, 1'b0, 12'h00F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
